// File: rtl/spi_flash_xip_reader_if.sv
// Request/response bus between the fetch path and the SPI flash XIP reader.
interface spi_flash_xip_reader_if;
  logic        req_valid;
  logic [23:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
  modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/spi_flash_xip_reader.sv
// Single-lane SPI flash 0x03 READ controller (mode 0) returning little-endian words,
// keeping chip-select low between sequential fetches so data streams without a new command.
module spi_flash_xip_reader #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned CS_GAP      = 2,
  parameter logic [7:0]  READ_CMD    = 8'h03
) (
  input  logic                         clk,
  input  logic                         RSTB,
  spi_flash_xip_reader_if.slave        bus,
  output logic                         fsclk,
  output logic                         fcen,
  output logic                         MOSI,
  input  logic                         MISO
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, HOLD, GAP} state_t;

  state_t      state_reg;
  logic [31:0] shift_reg;
  logic [31:0] rx_reg;
  logic [23:0] next_addr_reg;
  logic [21:0] pend_word_reg;
  logic        pend_valid_reg;
  logic [31:0] phase_cnt_reg;
  logic [31:0] wait_cnt_reg;
  logic [4:0]  bit_cnt_reg;
  logic        fsclk_reg;
  logic        fcen_reg;
  logic        mosi_reg;
  logic        ready_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_data_reg;

  logic        accept;
  logic        gap_done;
  logic        start;
  logic [21:0] start_word;
  logic        phase_rise;
  logic        bit_end;
  logic [31:0] rx_next;
  logic [31:0] rx_swapped;
  logic        unused_addr_bits;

  assign accept     = bus.req_valid && ready_reg;
  assign gap_done   = (wait_cnt_reg == CS_GAP - 1);
  assign start      = ((state_reg == IDLE) && accept) ||
                      ((state_reg == GAP) && gap_done && pend_valid_reg);
  assign start_word = (state_reg == GAP) ? pend_word_reg : bus.req_addr[23:2];
  assign phase_rise = (phase_cnt_reg == CLK_DIV - 1);
  assign bit_end    = (phase_cnt_reg == 2 * CLK_DIV - 1);
  assign rx_next    = {rx_reg[30:0], MISO};
  assign unused_addr_bits = ^bus.req_addr[1:0];

  // Bytes arrive first-byte-first; the first one must end up in the low lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_swap
      assign rx_swapped[8*gi +: 8] = rx_next[31-8*gi -: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (RSTB) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      rx_reg         <= '0;
      next_addr_reg  <= '0;
      pend_word_reg  <= '0;
      pend_valid_reg <= 1'b0;
      phase_cnt_reg  <= '0;
      wait_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      fsclk_reg      <= 1'b0;
      fcen_reg       <= 1'b1;
      mosi_reg       <= 1'b0;
      ready_reg      <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      if (start) begin
        shift_reg      <= {READ_CMD, start_word, 2'b00};
        mosi_reg       <= READ_CMD[7];
        next_addr_reg  <= {start_word, 2'b00} + 24'd4;
        fcen_reg       <= 1'b0;
        ready_reg      <= 1'b0;
        pend_valid_reg <= 1'b0;
        phase_cnt_reg  <= '0;
        bit_cnt_reg    <= '0;
        wait_cnt_reg   <= '0;
        state_reg      <= CMD;
      end else begin
        case (state_reg)
          IDLE: ;
          CMD, DATA: begin
            if (phase_rise) fsclk_reg <= 1'b1;
            if (bit_end) begin
              // MISO is sampled on the same edge that drops fsclk.
              fsclk_reg     <= 1'b0;
              phase_cnt_reg <= '0;
              bit_cnt_reg   <= bit_cnt_reg + 5'd1;
              if (state_reg == CMD) begin
                shift_reg <= {shift_reg[30:0], 1'b0};
                mosi_reg  <= shift_reg[30];
                if (bit_cnt_reg == 5'd31) begin
                  mosi_reg  <= 1'b0;
                  state_reg <= DATA;
                end
              end else begin
                rx_reg <= rx_next;
                if (bit_cnt_reg == 5'd31) begin
                  resp_valid_reg <= 1'b1;
                  resp_data_reg  <= rx_swapped;
                  wait_cnt_reg   <= '0;
                  if (HOLD_CYCLES == 0) begin
                    fcen_reg  <= 1'b1;
                    state_reg <= GAP;
                  end else begin
                    ready_reg <= 1'b1;
                    state_reg <= HOLD;
                  end
                end
              end
            end else begin
              phase_cnt_reg <= phase_cnt_reg + 32'd1;
            end
          end
          HOLD: begin
            if (accept) begin
              ready_reg <= 1'b0;
              if (bus.req_addr[23:2] == next_addr_reg[23:2]) begin
                next_addr_reg <= next_addr_reg + 24'd4;
                phase_cnt_reg <= '0;
                bit_cnt_reg   <= '0;
                state_reg     <= DATA;
              end else begin
                pend_valid_reg <= 1'b1;
                pend_word_reg  <= bus.req_addr[23:2];
                fcen_reg       <= 1'b1;
                wait_cnt_reg   <= '0;
                state_reg      <= GAP;
              end
            end else if (wait_cnt_reg == HOLD_CYCLES - 1) begin
              fcen_reg     <= 1'b1;
              ready_reg    <= 1'b0;
              wait_cnt_reg <= '0;
              state_reg    <= GAP;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 32'd1;
            end
          end
          GAP: begin
            if (gap_done) begin
              wait_cnt_reg <= '0;
              ready_reg    <= 1'b1;
              state_reg    <= IDLE;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 32'd1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign fsclk          = fsclk_reg;
  assign fcen           = fcen_reg;
  assign MOSI           = mosi_reg;
  assign bus.req_ready  = ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_data  = resp_data_reg;

endmodule

// File: doc/spi_flash_xip_reader.md
# spi_flash_xip_reader

Single-lane SPI flash read controller for the Hazard3 FPGA SoC. It sits between the SoC's instruction/data fetch path and the external flash pins (`fsclk`, `fcen`, `MOSI`, `MISO`). It accepts 32-bit word read requests and issues standard `0x03` READ transactions in SPI mode 0. It returns each word little-endian, and it keeps chip-select asserted between sequential fetches so that consecutive words stream without repeating the command.

## Interface

Parameters:
- `CLK_DIV`, 2: number of `clk` cycles per SCK phase (low or high); minimum 1. One SPI bit takes `2*CLK_DIV` cycles.
- `HOLD_CYCLES`, 64: idle cycles in HOLD before `fcen` is released. A value of 0 disables HOLD, so `fcen` is released right after every word.
- `CS_GAP`, 2: minimum number of cycles `fcen` stays high between transactions; minimum 1.
- `READ_CMD`, 8'h03: command byte.

Ports:
- `clk`, in, 1: system clock. The block uses this single clock only.
- `RSTB`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: read request.
- `req_addr`, in, 24: byte address. Bits [1:0] are ignored, so every read is word-aligned.
- `req_ready`, out, 1: request accepted on `req_valid && req_ready`.
- `resp_valid`, out, 1: one-cycle pulse; `resp_data` is valid in that cycle.
- `resp_data`, out, 32: read word. The first byte received lands in [7:0].
- `fsclk`, out, 1: SPI clock. Idles low.
- `fcen`, out, 1: flash chip-select, active low.
- `MOSI`, out, 1: serial data to the flash.
- `MISO`, in, 1: serial data from the flash.

## Operation

- Reset values: `fcen`=1, `fsclk`=0, `MOSI`=0, `resp_valid`=0, `resp_data`=0, `req_ready`=1. State is IDLE and the next-address register is cleared.
- States: IDLE, CMD, DATA, HOLD, GAP.
- IDLE:
  - `req_ready`=1.
  - On accept, the shift register loads `{READ_CMD, addr[23:2], 2'b00}` and `next_addr` becomes `addr+4` (24-bit wrap).
  - The block then moves to CMD, and `fcen` goes low in the following cycle.
- Bit timing:
  - Each bit has a low phase of `CLK_DIV` cycles, then a high phase of `CLK_DIV` cycles.
  - `MOSI` = shift MSB. It is updated only at the start of a low phase, so it is stable across the rising edge.
  - `MISO` is registered on the `clk` edge that ends the high phase, which is the same edge that drives `fsclk` low.
- CMD: shifts out 32 bits MSB-first, then moves to DATA. `MOSI` is driven 0 in every other state.
- DATA:
  - Shifts in 32 bits. Within each byte bits arrive MSB-first, and byte k is placed at `resp_data[8k+7:8k]`.
  - After bit 32, `resp_valid` pulses for one cycle, `fsclk` is low, and the state becomes HOLD. If `HOLD_CYCLES`=0 the state becomes GAP instead.
- HOLD:
  - `fcen`=0, `fsclk`=0, `req_ready`=1, and an idle counter runs.
  - Accept with `addr[23:2] == next_addr[23:2]`: go straight to DATA with no command; `next_addr` += 4.
  - Accept with any other address: the request is captured, `fcen` rises, and the state becomes GAP. The captured request starts automatically at the end of GAP.
  - If the counter reaches `HOLD_CYCLES` with no accept, `fcen` rises and the state becomes GAP.
- GAP:
  - `fcen`=1 and `req_ready`=0 for `CS_GAP` cycles.
  - At the end of GAP, the block starts the pending captured request in CMD, or returns to IDLE if there is none.
- Sequential wrap: `next_addr` 0xFFFFFC + 4 → 0x000000. The flash wraps its internal address the same way, so the continuation is still taken.
- Reset mid-transfer: on the next edge `fcen`=1 and `fsclk`=0, any pending request is dropped, and no `resp_valid` is produced.

## Timing

- Full read (from IDLE):
  - Accept in cycle 0; `fcen` falls at cycle 1.
  - 64 bits occupy cycles 1 through `128*CLK_DIV`.
  - `resp_valid` in cycle `128*CLK_DIV+1`, which is 257 cycles at `CLK_DIV`=2.
- Sequential read (from HOLD): `resp_valid` `64*CLK_DIV+1` cycles after accept, which is 129 cycles at `CLK_DIV`=2.
- Non-sequential read from HOLD: `CS_GAP` + the full-read latency.
- `fsclk` toggles only while `fcen`=0, and it is low whenever `fcen` changes.
- At most one request is outstanding; `req_ready`=0 throughout CMD, DATA and GAP.

## Test plan

- Reset: hold `RSTB`=1 for 10 cycles → `fcen`=1, `fsclk`=0, `MOSI`=0, `resp_valid`=0, `req_ready`=1.
- Single read: addr 0x000000, flash bytes 13 05 00 00, `CLK_DIV`=2 → `MOSI` stream 0x03000000, `resp_data`=0x00000513 at cycle 257, 64 `fsclk` rising edges.
- Sequential: read 0x000004 within 10 cycles of the previous response → no command bits, 32 `fsclk` edges, `fcen` stays low, `resp_valid` at +129 cycles.
- Non-sequential in HOLD: request 0x000100 → `fcen` high for exactly 2 cycles, then a full command with address 0x000100 and `resp_valid` at +259 cycles.
- Hold timeout: no request after a response → `fcen` rises exactly 64 cycles after `resp_valid`, and `req_ready`=0 for 2 cycles.
- Reset at cycle 100 of a read → `fcen`=1 and `fsclk`=0 the next cycle, no `resp_valid`, and a following read of 0x000000 returns 0x00000513.
